bankgroup_cmd_ctrl: RTL and testbench
=====================================

Name: bankgroup_cmd_ctrl

Overview:
- Initiator side of the per-bank bundled interface of a bank group.
- Accepts simple DRAM-style commands (ACT, RD, WR, PRE) from an upstream channel model.
- Tracks open/closed state and the open row for every bank, and drives the bank-indexed arrays rd_o_wr/dqin/row/column to execute fixed-length bursts.
- Returns read data from the bank-indexed dqout array on a single shared read port.

Parameters:
- BAWIDTH, 2, bank address width; BANKSPERGROUP = 2**BAWIDTH (localparam).
- COLWIDTH, 10, column address width.
- DEVICE_WIDTH, 4, data bits per beat.
- CHWIDTH, 5, row address width.
- BL, 8, burst length in beats; power of 2, 2..2**COLWIDTH.
- RDLAT, 1, cycles from a column presented on column[b] to valid data on dqout[b]; ≥1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd  in  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE; 5-7 treated as NOP.
- cmd_ba  in  BAWIDTH  target bank.
- cmd_row  in  CHWIDTH  row for ACT.
- cmd_col  in  COLWIDTH  start column for RD/WR.
- wdata  in  DEVICE_WIDTH  write beat data.
- rdata  out  DEVICE_WIDTH  read beat data.
- rdata_valid  out  1  rdata valid this cycle.
- err  out  1  one-cycle pulse on an illegal accepted command.
- bank_open  out  BANKSPERGROUP  per-bank open flag.
- rd_o_wr  out  [0:0] x BANKSPERGROUP  per-bank write strobe (1 = write, 0 = read/idle).
- dqin  out  [DEVICE_WIDTH-1:0] x BANKSPERGROUP  per-bank write data.
- dqout  in  [DEVICE_WIDTH-1:0] x BANKSPERGROUP  per-bank read data.
- row  out  [CHWIDTH-1:0] x BANKSPERGROUP  per-bank open row.
- column  out  [COLWIDTH-1:0] x BANKSPERGROUP  per-bank column.

Behaviour:
- Reset (async assert, sync release) forces the following:
  - All banks closed, bank_open=0, row[*]=0, column[*]=0, rd_o_wr[*]=0, dqin[*]=0.
  - rdata=0, rdata_valid=0, err=0, cmd_ready=1.
  - Any in-flight burst and the read-return pipeline are discarded; no rdata_valid after reset.
- Per-bank state: CLOSED / OPEN(row). Global sequencer FSM: IDLE, RBURST, WBURST.
- ACT (accepted cycle T):
  - Legal on a CLOSED bank: bank_open[ba]=1 and row[ba]=cmd_row from T+1.
  - On an OPEN bank: ignored, err=1 at T+1.
- PRE (cycle T):
  - bank_open[ba]=0, row[ba]=0 from T+1.
  - PRE on a CLOSED bank is a no-op with no err.
- RD/WR (cycle T):
  - On a CLOSED bank: ignored, err=1 at T+1, FSM stays IDLE.
  - Otherwise the FSM enters RBURST/WBURST and beat k (k=0..BL-1) occupies cycle T+1+k.
- Column sequence:
  - Beat k column = {cmd_col[COLWIDTH-1:log2 BL], (cmd_col[log2 BL-1:0]+k) mod BL}.
  - This wraps within the BL-aligned block; upper bits are never modified.
  - column[ba] is registered and holds its last value after the burst.
- WBURST:
  - In cycle T+1+k, rd_o_wr[ba]=1 and dqin[ba]=wdata (combinational pass-through of that cycle's wdata).
  - Upstream must present beat k on wdata in cycle T+1+k.
  - rd_o_wr of all other banks stays 0; rd_o_wr[ba] returns to 0 after the last beat.
- RBURST:
  - rd_o_wr[ba]=0; bank index and beat-valid are delayed RDLAT cycles.
  - rdata=dqout[delayed ba], with rdata_valid=1, in cycles T+1+RDLAT+k.
  - rdata is registered if RDLAT is counted inclusive of the capture stage; implementation keeps total latency exactly T+1+RDLAT+k.
- cmd_ready:
  - Low during cycles T+1..T+BL-1 of a burst; high in cycle T+BL.
  - A RD/WR accepted at T+BL starts its first beat at T+BL+1 (gapless back-to-back).
  - ACT/PRE/NOP are blocked during the same window.
- Read return pipeline overlap:
  - The read return pipeline is independent of the FSM, so a WR may follow a RD gaplessly while read data drains.
  - WR beats never corrupt the delayed bank index of pending read beats.
- err does not alter any bank state. NOP and codes 5-7 are accepted with no effect.

Test Plan:
- Reset mid-burst: assert rst during beat 3 of a RD → all outputs 0 immediately, cmd_ready=1 after release, no rdata_valid ever follows.
- ACT bank 2 row 5, WR col 0x00A with wdata 1..8, then RD col 0x00A (BL=8, RDLAT=1):
  - Write columns 0x00A..0x00F,0x008,0x009 with rd_o_wr[2]=1 for exactly 8 cycles.
  - Read returns 1..8, rdata_valid on 8 consecutive cycles starting T_rd+2.
- Back-to-back: RD bank0 accepted at T, RD bank1 accepted at T+8 → 16 consecutive rdata_valid cycles; first 8 from dqout[0], next 8 from dqout[1].
- Illegal: RD to closed bank 3 → err=1 for one cycle, no rd_o_wr/column change; ACT to already-open bank 1 row 7 → err, row[1] unchanged.
- PRE bank 2, then WR bank 2 → bank_open[2]=0, row[2]=0, WR flagged err, rd_o_wr[2] stays 0.
- cmd_ready: during a burst accepted at T, cmd_ready=0 for T+1..T+7 and 1 at T+8; a held cmd_valid is accepted exactly at T+8.

Source files
------------

// File: rtl/bankgroup_cmd_ctrl.sv
// Bank-group command initiator: tracks per-bank open/row state and sequences
// fixed-length read/write bursts onto the bank-indexed array interface.
module bankgroup_cmd_ctrl #(
    parameter int BAWIDTH      = 2,
    parameter int COLWIDTH     = 10,
    parameter int DEVICE_WIDTH = 4,
    parameter int CHWIDTH      = 5,
    parameter int BL           = 8,
    parameter int RDLAT        = 1,
    localparam int BANKSPERGROUP = 2**BAWIDTH
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          cmd_valid,
    output logic                                          cmd_ready,
    input  logic [2:0]                                    cmd,
    input  logic [BAWIDTH-1:0]                            cmd_ba,
    input  logic [CHWIDTH-1:0]                            cmd_row,
    input  logic [COLWIDTH-1:0]                           cmd_col,
    input  logic [DEVICE_WIDTH-1:0]                       wdata,
    output logic [DEVICE_WIDTH-1:0]                       rdata,
    output logic                                          rdata_valid,
    output logic                                          err,
    output logic [BANKSPERGROUP-1:0]                      bank_open,
    output logic [BANKSPERGROUP-1:0]                      rd_o_wr,
    output logic [BANKSPERGROUP-1:0][DEVICE_WIDTH-1:0]    dqin,
    input  logic [BANKSPERGROUP-1:0][DEVICE_WIDTH-1:0]    dqout,
    output logic [BANKSPERGROUP-1:0][CHWIDTH-1:0]         row,
    output logic [BANKSPERGROUP-1:0][COLWIDTH-1:0]        column
);

    // state   | meaning
    // IDLE    | no burst, commands accepted every cycle
    // RBURST  | read burst beats on column[ba_q]
    // WBURST  | write burst beats, wdata passed to dqin[ba_q]
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RBURST = 2'd1;
    localparam logic [1:0] S_WBURST = 2'd2;

    localparam logic [2:0] C_ACT = 3'd1;
    localparam logic [2:0] C_RD  = 3'd2;
    localparam logic [2:0] C_WR  = 3'd3;
    localparam logic [2:0] C_PRE = 3'd4;

    localparam int BEATW = $clog2(BL);
    localparam logic [COLWIDTH-1:0] COL_MASK = COLWIDTH'(BL - 1);
    localparam logic [BEATW-1:0]    LAST_BEAT = BEATW'(BL - 1);

    logic [1:0]                                   state_q, state_d;
    logic [BEATW-1:0]                             beat_q, beat_d;
    logic [BAWIDTH-1:0]                           ba_q, ba_d;
    logic [BANKSPERGROUP-1:0]                     open_q, open_d;
    logic [BANKSPERGROUP-1:0][CHWIDTH-1:0]        row_q, row_d;
    logic [BANKSPERGROUP-1:0][COLWIDTH-1:0]       col_q, col_d;
    logic                                         err_q, err_d;
    logic [RDLAT-1:0]                             rv_q;
    logic [RDLAT-1:0][BAWIDTH-1:0]                rba_q;

    logic accept;
    logic in_burst;
    logic last_beat;
    logic [COLWIDTH-1:0] col_cur;

    assign in_burst  = (state_q != S_IDLE);
    assign last_beat = in_burst && (beat_q == LAST_BEAT);
    assign cmd_ready = !in_burst || last_beat;
    assign accept    = cmd_valid && cmd_ready;
    assign col_cur   = col_q[ba_q];

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        ba_d    = ba_q;
        open_d  = open_q;
        row_d   = row_q;
        col_d   = col_q;
        err_d   = 1'b0;

        // Column wraps inside the BL-aligned block; the last beat's column is held.
        if (in_burst) begin
            beat_d = beat_q + BEATW'(1);
            if (last_beat) begin
                state_d = S_IDLE;
            end else begin
                col_d[ba_q] = (col_cur & ~COL_MASK) | ((col_cur + COLWIDTH'(1)) & COL_MASK);
            end
        end

        if (accept) begin
            case (cmd)
                C_ACT: begin
                    if (open_q[cmd_ba]) begin
                        err_d = 1'b1;
                    end else begin
                        open_d[cmd_ba] = 1'b1;
                        row_d[cmd_ba]  = cmd_row;
                    end
                end
                C_PRE: begin
                    open_d[cmd_ba] = 1'b0;
                    row_d[cmd_ba]  = '0;
                end
                C_RD, C_WR: begin
                    if (!open_q[cmd_ba]) begin
                        err_d = 1'b1;
                    end else begin
                        state_d        = (cmd == C_RD) ? S_RBURST : S_WBURST;
                        beat_d         = '0;
                        ba_d           = cmd_ba;
                        col_d[cmd_ba]  = cmd_col;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            ba_q    <= '0;
            open_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            ba_q    <= ba_d;
            open_q  <= open_d;
            row_q   <= row_d;
            col_q   <= col_d;
            err_q   <= err_d;
        end
    end

    // Read-return pipeline runs independently of the FSM so a WR can follow a RD gaplessly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rv_q  <= '0;
            rba_q <= '0;
        end else begin
            rv_q[0]  <= (state_q == S_RBURST);
            rba_q[0] <= ba_q;
            for (int i = 1; i < RDLAT; i++) begin
                rv_q[i]  <= rv_q[i-1];
                rba_q[i] <= rba_q[i-1];
            end
        end
    end

    always_comb begin
        rd_o_wr = '0;
        dqin    = '0;
        if (state_q == S_WBURST) begin
            rd_o_wr[ba_q] = 1'b1;
            dqin[ba_q]    = wdata;
        end
    end

    // dqout is already RDLAT cycles behind the column, so the return mux stays combinational.
    assign rdata_valid = rv_q[RDLAT-1];
    assign rdata       = rdata_valid ? dqout[rba_q[RDLAT-1]] : '0;
    assign err         = err_q;
    assign bank_open   = open_q;
    assign row         = row_q;
    assign column      = col_q;

endmodule

// File: tb/tb_bankgroup_cmd_ctrl.sv
// Randomized and directed stimulus for bankgroup_cmd_ctrl, checked every cycle
// against a cycle-indexed schedule model of bank state, bursts and read returns.
module tb_bankgroup_cmd_ctrl;

    localparam int BAW   = 2;
    localparam int COLW  = 10;
    localparam int DW    = 4;
    localparam int CHW   = 5;
    localparam int BL    = 8;
    localparam int RDLAT = 1;
    localparam int NB    = 2**BAW;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     cmd_valid = 1'b0;
    logic                     cmd_ready;
    logic [2:0]               cmd = '0;
    logic [BAW-1:0]           cmd_ba = '0;
    logic [CHW-1:0]           cmd_row = '0;
    logic [COLW-1:0]          cmd_col = '0;
    logic [DW-1:0]            wdata = '0;
    logic [DW-1:0]            rdata;
    logic                     rdata_valid;
    logic                     err;
    logic [NB-1:0]            bank_open;
    logic [NB-1:0]            rd_o_wr;
    logic [NB-1:0][DW-1:0]    dqin;
    logic [NB-1:0][DW-1:0]    dqout = '0;
    logic [NB-1:0][CHW-1:0]   row;
    logic [NB-1:0][COLW-1:0]  column;

    bankgroup_cmd_ctrl #(
        .BAWIDTH(BAW), .COLWIDTH(COLW), .DEVICE_WIDTH(DW),
        .CHWIDTH(CHW), .BL(BL), .RDLAT(RDLAT)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd(cmd), .cmd_ba(cmd_ba), .cmd_row(cmd_row), .cmd_col(cmd_col),
        .wdata(wdata), .rdata(rdata), .rdata_valid(rdata_valid), .err(err),
        .bank_open(bank_open), .rd_o_wr(rd_o_wr), .dqin(dqin), .dqout(dqout),
        .row(row), .column(column)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: per-bank state plus per-cycle schedules of burst effects.
    bit mopen[NB];
    int mrow[NB];
    int mcol[NB];
    int ready_at = 0;
    int wr_s[int];
    int rd_s[int];
    int cb_s[int];
    int cv_s[int];
    bit err_s[int];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int b = 0; b < NB; b++) begin
            mopen[b] = 0; mrow[b] = 0; mcol[b] = 0;
        end
        ready_at = cyc;
        wr_s.delete(); rd_s.delete(); cb_s.delete(); cv_s.delete(); err_s.delete();
    endtask

    task automatic check_cycle();
        logic [63:0] e_open, e_row, e_col, e_wr, e_dqin, e_rdata;
        if (cb_s.exists(cyc)) mcol[cb_s[cyc]] = cv_s[cyc];
        e_open = '0; e_row = '0; e_col = '0; e_wr = '0; e_dqin = '0; e_rdata = '0;
        for (int b = 0; b < NB; b++) begin
            e_open[b]            = mopen[b];
            e_row[b*CHW +: CHW]  = CHW'(mrow[b]);
            e_col[b*COLW +: COLW] = COLW'(mcol[b]);
        end
        if (wr_s.exists(cyc)) begin
            e_wr[wr_s[cyc]] = 1'b1;
            e_dqin[wr_s[cyc]*DW +: DW] = wdata;
        end
        if (rd_s.exists(cyc)) e_rdata = 64'(dqout[rd_s[cyc]]);
        chk("cmd_ready", 64'(cmd_ready), 64'(cyc >= ready_at));
        chk("err", 64'(err), 64'(err_s.exists(cyc)));
        chk("bank_open", 64'(bank_open), e_open);
        chk("row", 64'(row), e_row);
        chk("column", 64'(column), e_col);
        chk("rd_o_wr", 64'(rd_o_wr), e_wr);
        chk("dqin", 64'(dqin), e_dqin);
        chk("rdata_valid", 64'(rdata_valid), 64'(rd_s.exists(cyc)));
        chk("rdata", 64'(rdata), e_rdata);
    endtask

    task automatic model_accept(input bit v, input int c, input int b, input int r,
                                input int col, output bit acc);
        acc = v && (cyc >= ready_at);
        if (acc) begin
            case (c)
                1: if (mopen[b]) err_s[cyc+1] = 1;
                   else begin mopen[b] = 1; mrow[b] = r; end
                4: begin mopen[b] = 0; mrow[b] = 0; end
                2, 3: if (!mopen[b]) err_s[cyc+1] = 1;
                   else begin
                       ready_at = cyc + BL;
                       for (int k = 0; k < BL; k++) begin
                           cb_s[cyc+1+k] = b;
                           cv_s[cyc+1+k] = (col & ~(BL-1)) | ((col + k) % BL);
                           if (c == 3) wr_s[cyc+1+k] = b;
                           else rd_s[cyc+1+k+RDLAT] = b;
                       end
                   end
                default: ;
            endcase
        end
    endtask

    task automatic step(input bit v, input int c, input int b, input int r,
                        input int col, output bit acc);
        @(negedge clk);
        cmd_valid = v;
        cmd       = 3'(c);
        cmd_ba    = BAW'(b);
        cmd_row   = CHW'(r);
        cmd_col   = COLW'(col);
        wdata     = DW'($urandom);
        dqout     = (NB*DW)'($urandom);
        #1;
        check_cycle();
        model_accept(v, c, b, r, col, acc);
        cyc++;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, acc);
    endtask

    task automatic issue(input int c, input int b, input int r, input int col);
        bit acc;
        int n;
        n = 0;
        acc = 0;
        while (!acc && n < 2*BL) begin
            step(1, c, b, r, col, acc);
            n++;
        end
        if (!acc) chk("issue_timeout", 64'(acc), 64'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        cmd_valid = 0;
        cmd = '0;
        rst = 1'b1;
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_open", 64'(bank_open), 64'd0);
        chk("rst_rd_o_wr", 64'(rd_o_wr), 64'd0);
        chk("rst_dqin", 64'(dqin), 64'd0);
        chk("rst_row", 64'(row), 64'd0);
        chk("rst_column", 64'(column), 64'd0);
        chk("rst_rdata_valid", 64'(rdata_valid), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit acc;
        do_reset();

        // Write then read the same wrapped block on bank 2.
        issue(1, 2, 5, 0);
        issue(3, 2, 0, 'h00A);
        issue(2, 2, 0, 'h00A);
        idle(12);

        // Back-to-back reads on banks 0 and 1, then a gapless WR after a RD.
        issue(1, 0, 3, 0);
        issue(1, 1, 9, 0);
        issue(2, 0, 0, 'h3F5);
        issue(2, 1, 0, 'h101);
        issue(3, 0, 0, 'h007);
        idle(12);

        // Illegal commands.
        issue(2, 3, 0, 'h011);
        issue(1, 1, 7, 0);
        issue(4, 2, 0, 0);
        issue(3, 2, 0, 'h020);
        issue(4, 3, 0, 0);
        idle(4);

        // Held cmd_valid behind a burst, and unused opcodes.
        issue(3, 1, 0, 'h0FF);
        issue(1, 2, 17, 0);
        issue(6, 0, 0, 0);
        issue(0, 0, 0, 0);
        idle(4);

        // Reset during beat 3 of a read.
        issue(2, 0, 0, 'h044);
        idle(3);
        do_reset();
        idle(BL + RDLAT + 4);

        for (int i = 0; i < 800; i++) begin
            int c;
            c = (($urandom_range(0, 3) == 0)) ? 1 : int'($urandom_range(0, 7));
            step($urandom_range(0, 3) != 0, c, $urandom_range(0, NB-1),
                 $urandom_range(0, 2**CHW-1), $urandom_range(0, 2**COLW-1), acc);
        end
        idle(BL + RDLAT + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
